// File: rtl/alu_op_sequencer.sv
// Command sequencer for the 4-bit-opcode calculator datapath: registers one
// operation, holds the ALU inputs ALU_LAT cycles, captures and returns the result.
module alu_op_sequencer #(
  parameter int N       = 4,
  parameter int ALU_LAT = 1,
  parameter int CW      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [N-1:0]     cmd_a,
  input  logic [N-1:0]     cmd_b,
  input  logic             cmd_use_acc,
  output logic [3:0]       alu_op,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  input  logic [2*N-1:0]   alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*N-1:0]   rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [N-1:0]     acc,
  output logic             busy,
  output logic [CW-1:0]    op_count
);

  localparam int CNTW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t            r_state;
  logic [CNTW-1:0]   r_wait;
  logic [3:0]        r_alu_op;
  logic [N-1:0]      r_alu_a;
  logic [N-1:0]      r_alu_b;
  logic              r_rsp_valid;
  logic [2*N-1:0]    r_rsp_result;
  logic              r_rsp_zero;
  logic              r_rsp_err;
  logic [N-1:0]      r_acc;
  logic [CW-1:0]     r_op_count;

  logic              w_div_zero;
  logic              w_res_zero;

  // Opcodes 3 (div) and 4 (mod) with a zero divisor are reported as errors.
  assign w_div_zero = ((r_alu_op == 4'd3) || (r_alu_op == 4'd4)) && (r_alu_b == '0);
  assign w_res_zero = (alu_result == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wait       <= '0;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_acc        <= '0;
      r_op_count   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_alu_op <= cmd_op;
            r_alu_a  <= cmd_use_acc ? r_acc : cmd_a;
            r_alu_b  <= cmd_b;
            r_wait   <= CNTW'(ALU_LAT - 1);
            r_state  <= EXEC;
          end
        end
        EXEC: begin
          if (r_wait != '0) begin
            r_wait <= r_wait - CNTW'(1);
          end else begin
            if (w_div_zero) begin
              r_rsp_err    <= 1'b1;
              r_rsp_result <= '0;
              r_rsp_zero   <= 1'b0;
            end else begin
              r_rsp_err    <= 1'b0;
              r_rsp_result <= alu_result;
              r_rsp_zero   <= w_res_zero;
              r_acc        <= alu_result[N-1:0];
            end
            r_rsp_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // rsp_* data stays put after the handshake; only valid drops.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + CW'(1);
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = (r_state == IDLE);
  assign busy       = (r_state != IDLE);
  assign alu_op     = r_alu_op;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;
  assign acc        = r_acc;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vector table, hand-written corner
// sequences, and a random run against a transaction-level reference model.
module tb_alu_op_sequencer;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Calculator stand-in; div/mod by zero return junk the sequencer must hide.
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
    logic [7:0] wa, wb;
    wa = {4'b0, a};
    wb = {4'b0, b};
    case (op)
      4'd0: return wa + wb;
      4'd1: return wa - wb;
      4'd2: return wa * wb;
      4'd3: return (b == 4'd0) ? 8'hFF : wa / wb;
      4'd4: return (b == 4'd0) ? 8'hEE : wa % wb;
      4'd5: return wa & wb;
      4'd6: return wa | wb;
      4'd7: return wa ^ wb;
      4'd8: return wa << b;
      4'd9: return wa >> b;
      default: return {a, b};
    endcase
  endfunction

  // Group A drives two LAT=1 instances (CW=8 and CW=2) with identical stimulus.
  logic       rst_a, cv_a, ua_a, rr_a;
  logic [3:0] op_a, a_a, b_a;
  logic       rdy1, rv1, rz1, re1, busy1;
  logic [3:0] op1, aa1, bb1, acc1;
  logic [7:0] ar1, res1, cnt1;
  logic       rdyw, rvw, rzw, rew, busyw;
  logic [3:0] opw, aaw, bbw, accw;
  logic [7:0] arw, resw;
  logic [1:0] cntw;

  logic       rst_b, cv_b, ua_b, rr_b;
  logic [3:0] op_b, a_b, b_b;
  logic       rdy3, rv3, rz3, re3, busy3;
  logic [3:0] op3, aa3, bb3, acc3;
  logic [7:0] ar3, res3, cnt3;

  assign ar1 = alu_fn(op1, aa1, bb1);
  assign arw = alu_fn(opw, aaw, bbw);
  assign ar3 = alu_fn(op3, aa3, bb3);

  alu_op_sequencer #(.N(4), .ALU_LAT(1), .CW(8)) dut1 (
    .clk(clk), .rst(rst_a), .cmd_valid(cv_a), .cmd_ready(rdy1), .cmd_op(op_a),
    .cmd_a(a_a), .cmd_b(b_a), .cmd_use_acc(ua_a), .alu_op(op1), .alu_a(aa1),
    .alu_b(bb1), .alu_result(ar1), .rsp_valid(rv1), .rsp_ready(rr_a),
    .rsp_result(res1), .rsp_zero(rz1), .rsp_err(re1), .acc(acc1), .busy(busy1),
    .op_count(cnt1));

  alu_op_sequencer #(.N(4), .ALU_LAT(1), .CW(2)) dutw (
    .clk(clk), .rst(rst_a), .cmd_valid(cv_a), .cmd_ready(rdyw), .cmd_op(op_a),
    .cmd_a(a_a), .cmd_b(b_a), .cmd_use_acc(ua_a), .alu_op(opw), .alu_a(aaw),
    .alu_b(bbw), .alu_result(arw), .rsp_valid(rvw), .rsp_ready(rr_a),
    .rsp_result(resw), .rsp_zero(rzw), .rsp_err(rew), .acc(accw), .busy(busyw),
    .op_count(cntw));

  alu_op_sequencer #(.N(4), .ALU_LAT(3), .CW(8)) dut3 (
    .clk(clk), .rst(rst_b), .cmd_valid(cv_b), .cmd_ready(rdy3), .cmd_op(op_b),
    .cmd_a(a_b), .cmd_b(b_b), .cmd_use_acc(ua_b), .alu_op(op3), .alu_a(aa3),
    .alu_b(bb3), .alu_result(ar3), .rsp_valid(rv3), .rsp_ready(rr_b),
    .rsp_result(res3), .rsp_zero(rz3), .rsp_err(re3), .acc(acc3), .busy(busy3),
    .op_count(cnt3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] op, a, b;
    logic       ua;
    logic [3:0] exp_a;
    logic [7:0] res;
    logic       z, e;
    logic [3:0] acc;
  } vec_t;

  vec_t vt[13];

  // Reference model state (transaction level).
  int         m_exec, m_cnt;
  bit         m_rsp, m_z, m_e;
  logic [3:0] m_op, m_a, m_b, m_acc;
  logic [7:0] m_res;

  task automatic model_reset();
    m_exec = 0; m_cnt = 0; m_rsp = 0; m_z = 0; m_e = 0;
    m_op = '0; m_a = '0; m_b = '0; m_acc = '0; m_res = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    //            op    a     b     ua    exp_a  res    z  e  acc
    vt[0]  = '{4'd0, 4'd5, 4'd3, 1'b0, 4'd5,  8'd8,   0, 0, 4'd8};
    vt[1]  = '{4'd2, 4'd15,4'd15,1'b0, 4'd15, 8'd225, 0, 0, 4'd1};
    vt[2]  = '{4'd8, 4'd7, 4'd2, 1'b1, 4'd1,  8'd4,   0, 0, 4'd4};
    vt[3]  = '{4'd3, 4'd9, 4'd0, 1'b0, 4'd9,  8'd0,   0, 1, 4'd4};
    vt[4]  = '{4'd4, 4'd9, 4'd0, 1'b0, 4'd9,  8'd0,   0, 1, 4'd4};
    vt[5]  = '{4'd1, 4'd7, 4'd7, 1'b0, 4'd7,  8'd0,   1, 0, 4'd0};
    vt[6]  = '{4'd7, 4'd12,4'd10,1'b0, 4'd12, 8'd6,   0, 0, 4'd6};
    vt[7]  = '{4'd12,4'd3, 4'd5, 1'b0, 4'd3,  8'h35,  0, 0, 4'd5};
    vt[8]  = '{4'd9, 4'd0, 4'd1, 1'b1, 4'd5,  8'd2,   0, 0, 4'd2};
    vt[9]  = '{4'd3, 4'd13,4'd4, 1'b0, 4'd13, 8'd3,   0, 0, 4'd3};
    vt[10] = '{4'd4, 4'd8, 4'd2, 1'b1, 4'd3,  8'd1,   0, 0, 4'd1};
    vt[11] = '{4'd1, 4'd2, 4'd5, 1'b0, 4'd2,  8'd253, 0, 0, 4'd13};
    vt[12] = '{4'd6, 4'd0, 4'd0, 1'b0, 4'd0,  8'd0,   1, 0, 4'd0};

    rst_a = 1; cv_a = 0; ua_a = 0; rr_a = 0; op_a = '0; a_a = '0; b_a = '0;
    rst_b = 1; cv_b = 0; ua_b = 0; rr_b = 0; op_b = '0; a_b = '0; b_b = '0;
    tick(); tick();
    rst_a = 0; rst_b = 0;

    chk("rst_ready", 32'(rdy1), 1);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_valid", 32'(rv1), 0);
    chk("rst_acc", 32'(acc1), 0);
    chk("rst_count", 32'(cnt1), 0);
    chk("rst_result", 32'(res1), 0);
    chk("rst_aluop", 32'(op1), 0);

    // Directed vector table, LAT=1, rsp_ready tied high.
    rr_a = 1;
    for (int i = 0; i < 13; i++) begin
      cv_a = 1; op_a = vt[i].op; a_a = vt[i].a; b_a = vt[i].b; ua_a = vt[i].ua;
      tick();
      cv_a = 0;
      chk("v_aluop", 32'(op1), 32'(vt[i].op));
      chk("v_alua", 32'(aa1), 32'(vt[i].exp_a));
      n = 0;
      while (!rv1 && n < 20) begin tick(); n++; end
      chk("v_latency", 32'(n), 1);
      chk("v_result", 32'(res1), 32'(vt[i].res));
      chk("v_zero", 32'(rz1), 32'(vt[i].z));
      chk("v_err", 32'(re1), 32'(vt[i].e));
      chk("v_acc", 32'(acc1), 32'(vt[i].acc));
      tick();
      chk("v_count", 32'(cnt1), 32'(i + 1));
      chk("v_count_wrap", 32'(cntw), 32'((i + 1) % 4));
      chk("v_valid_drop", 32'(rv1), 0);
      chk("v_ready_back", 32'(rdy1), 1);
      chk("v_result_hold", 32'(res1), 32'(vt[i].res));
    end

    // Backpressure: response held, a second command ignored until handshake.
    rr_a = 0; cv_a = 1; op_a = 4'd1; a_a = 4'd7; b_a = 4'd7; ua_a = 0;
    tick();
    op_a = 4'd0; a_a = 4'd1; b_a = 4'd1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(rv1), 1);
      chk("bp_result", 32'(res1), 0);
      chk("bp_zero", 32'(rz1), 1);
      chk("bp_ready", 32'(rdy1), 0);
      chk("bp_aluop", 32'(op1), 1);
      tick();
    end
    rr_a = 1;
    tick();
    chk("bp_drop", 32'(rv1), 0);
    chk("bp_not_yet", 32'(op1), 1);
    chk("bp_count", 32'(cnt1), 14);
    tick();
    cv_a = 0;
    chk("bp_accept_op", 32'(op1), 0);
    chk("bp_accept_a", 32'(aa1), 1);
    n = 0;
    while (!rv1 && n < 20) begin tick(); n++; end
    chk("bp_second_result", 32'(res1), 2);
    tick();

    // LAT=3: inputs held, result exactly three edges after accept.
    rr_b = 1; cv_b = 1; op_b = 4'd5; a_b = 4'd12; b_b = 4'd10;
    tick();
    cv_b = 0; op_b = 4'd0; a_b = 4'd0; b_b = 4'd0;
    for (int k = 1; k <= 3; k++) begin
      chk("l3_hold_op", 32'(op3), 5);
      chk("l3_hold_a", 32'(aa3), 12);
      chk("l3_hold_b", 32'(bb3), 10);
      chk("l3_busy", 32'(busy3), 1);
      tick();
      chk("l3_valid_timing", 32'(rv3), 32'(k == 3));
    end
    chk("l3_result", 32'(res3), 8);
    chk("l3_acc", 32'(acc3), 8);
    tick();
    chk("l3_count", 32'(cnt3), 1);
    chk("l3_idle", 32'(rdy3), 1);

    // Reset in the middle of EXEC drops the command.
    cv_b = 1; op_b = 4'd0; a_b = 4'd1; b_b = 4'd1;
    tick();
    cv_b = 0;
    tick();
    rst_b = 1;
    tick();
    rst_b = 0;
    chk("mr_ready", 32'(rdy3), 1);
    chk("mr_busy", 32'(busy3), 0);
    chk("mr_valid", 32'(rv3), 0);
    chk("mr_acc", 32'(acc3), 0);
    chk("mr_count", 32'(cnt3), 0);
    chk("mr_result", 32'(res3), 0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (rv3) seen = 1;
    end
    chk("mr_no_response", 32'(seen), 0);

    // First use_acc after reset sees acc = 0.
    cv_b = 1; ua_b = 1; op_b = 4'd0; a_b = 4'd9; b_b = 4'd6;
    tick();
    cv_b = 0; ua_b = 0;
    chk("ua_rst_alua", 32'(aa3), 0);
    n = 0;
    while (!rv3 && n < 20) begin tick(); n++; end
    chk("ua_rst_latency", 32'(n), 3);
    chk("ua_rst_result", 32'(res3), 6);
    tick();

    // Random traffic on group A against the reference model.
    rst_a = 1;
    tick();
    rst_a = 0;
    model_reset();
    for (int c = 0; c < 700; c++) begin
      rst_a = ($urandom_range(0, 99) == 0);
      cv_a  = $urandom_range(0, 1);
      op_a  = 4'($urandom_range(0, 15));
      a_a   = 4'($urandom_range(0, 15));
      b_a   = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ua_a  = $urandom_range(0, 1);
      rr_a  = ($urandom_range(0, 9) < 6);
      tick();
      if (rst_a) begin
        model_reset();
      end else if (m_rsp) begin
        if (rr_a) begin m_rsp = 0; m_cnt = (m_cnt + 1) % 256; end
      end else if (m_exec > 0) begin
        m_exec--;
        if (m_exec == 0) begin
          if ((m_op == 4'd3 || m_op == 4'd4) && m_b == 4'd0) begin
            m_res = 8'd0; m_z = 0; m_e = 1;
          end else begin
            m_res = alu_fn(m_op, m_a, m_b);
            m_z = (m_res == 8'd0); m_e = 0;
            m_acc = m_res[3:0];
          end
          m_rsp = 1;
        end
      end else if (cv_a) begin
        m_op = op_a; m_a = ua_a ? m_acc : a_a; m_b = b_a; m_exec = 1;
      end
      chk("r_ready", 32'(rdy1), 32'(!m_rsp && m_exec == 0));
      chk("r_valid", 32'(rv1), 32'(m_rsp));
      chk("r_acc", 32'(acc1), 32'(m_acc));
      chk("r_count", 32'(cnt1), 32'(m_cnt));
      chk("r_count_wrap", 32'(cntw), 32'(m_cnt % 4));
      chk("r_alu", 32'({op1, aa1, bb1}), 32'({m_op, m_a, m_b}));
      chk("r_rsp", 32'({res1, rz1, re1}), 32'({m_res, m_z, m_e}));
    end
    rst_a = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Controller that sequences the team's 4-bit-opcode calculator datapath (add, sub, mul, div, mod, and, or, xor, shl, shr) on behalf of one command source.
- Accepts one operation at a time through a valid/ready command port and registers the operands.
- Holds the ALU inputs stable for a programmable number of cycles, then captures the 2N-bit result.
- Flags zero and divide-by-zero, and keeps an accumulator so commands can chain on the previous result.
- Sits between a front end (switch/UART decoder) and the combinational calculator instance.

Parameters:
- N, 4, operand width; the ALU result is 2N bits.
- ALU_LAT, 1, cycles the ALU inputs are held before the result is sampled; legal range is 1 or more.
- CW, 8, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  4  opcode; same encoding as the calculator's select input.
- cmd_a  in  N  operand A.
- cmd_b  in  N  operand B.
- cmd_use_acc  in  1  1 = use the accumulator instead of cmd_a.
- alu_op  out  4  registered opcode to the ALU.
- alu_a  out  N  registered operand A to the ALU.
- alu_b  out  N  registered operand B to the ALU.
- alu_result  in  2N  ALU result (combinational from alu_*).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  2N  captured result.
- rsp_zero  out  1  rsp_result == 0 and no error.
- rsp_err  out  1  divide or modulo by zero.
- acc  out  N  accumulator value.
- busy  out  1  state is not IDLE.
- op_count  out  CW  completed responses, wrapping.

Behaviour:
- Reset, synchronous, highest priority, also mid-operation:
  - state goes to IDLE.
  - alu_op, alu_a, alu_b, rsp_result, acc and op_count clear to 0.
  - rsp_valid, rsp_zero and rsp_err clear to 0.
  - Any in-flight command is dropped and no response is produced.
- States are IDLE, EXEC and DONE.
  - cmd_ready is 1 only in IDLE. busy = (state != IDLE).
- IDLE:
  - When cmd_valid is 1, accept the command at that edge.
  - alu_op <= cmd_op.
  - alu_a <= cmd_use_acc ? acc : cmd_a.
  - alu_b <= cmd_b.
  - The wait counter loads ALU_LAT-1 and the state goes to EXEC.
- EXEC:
  - alu_* are held constant.
  - Each cycle the counter decrements while it is not 0.
  - At the edge where the counter is 0, capture the result and go to DONE.
  - rsp_valid is therefore high exactly ALU_LAT cycles after the accept edge.
- Capture, divide-by-zero case: if alu_op is 3 or 4 and alu_b == 0:
  - rsp_err = 1, rsp_result = 0, rsp_zero = 0.
  - acc is unchanged.
- Capture, all other cases:
  - rsp_err = 0 and rsp_result = alu_result.
  - rsp_zero = (alu_result == 0).
  - acc <= alu_result[N-1:0], truncated with no saturation.
- DONE:
  - rsp_valid = 1 and all rsp_* are held stable until rsp_valid && rsp_ready.
  - On that handshake edge: rsp_valid <= 0, op_count increments (errors included, wraps 2^CW-1 -> 0), state goes to IDLE.
  - rsp_* keep their last values after the handshake; only rsp_valid drops.
- Commands presented while not in IDLE are ignored (cmd_ready = 0). No queueing.
- Throughput: minimum accept-to-accept is ALU_LAT+2 cycles with rsp_ready tied high.
- cmd_use_acc on the first command after reset uses acc = 0.
- Opcodes 10-15 are passed through unmodified; the ALU defines their result.
- rsp_ready high while rsp_valid is low has no effect.

Test Plan (N=4, ALU_LAT=1 unless noted):
- Reset, then add 5+3 (op 0) with rsp_ready=1 -> rsp_valid pulses 1 cycle after accept; rsp_result=8, rsp_zero=0, acc=8, op_count=1.
- mul 15*15 (op 2) -> rsp_result=225 (0xE1), acc=1 (truncated).
  - Then shl (op 8) with cmd_use_acc=1, b=2 -> alu_a=1, rsp_result=4, acc=4.
- div 9/0 (op 3) -> rsp_err=1, rsp_result=0, rsp_zero=0, acc unchanged; op_count still increments.
  - mod 9/0 (op 4) gives the same.
- Backpressure: sub 7-7 (op 1), rsp_ready held low 5 cycles.
  - rsp_valid stays 1 with rsp_result=0 and rsp_zero=1 constant; cmd_ready=0.
  - A second cmd_valid is ignored; after rsp_ready=1 the next command is accepted ALU_LAT+2 cycles after the first accept at the earliest.
- ALU_LAT=3: and 12&10 (op 5) -> alu_* stable 3 cycles, rsp_result=8 exactly 3 cycles after the accept edge.
- rst asserted during EXEC (ALU_LAT=3) -> next cycle: IDLE, cmd_ready=1, rsp_valid=0, acc=0, op_count=0, and no response ever appears.
- op_count wrap (CW=2): 5 completed ops -> op_count sequence 1,2,3,0,1.
